// File: rtl/bluetooth_uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// bluetooth_uart_rx_pkg
//  Shared definitions for the Bluetooth UART receiver:
//   - mode codes consumed by the control unit (MODO_OFF/LER/BT_ON/BT_RST)
//   - ASCII command letters (upper and lower case)
//   - receiver FSM state encoding
//   - decode_letter(): maps a received byte to {hit, mode code}
// -----------------------------------------------------------------------------
package bluetooth_uart_rx_pkg;

   localparam logic [2:0] MODO_OFF    = 3'b000;
   localparam logic [2:0] MODO_LER    = 3'b001;
   localparam logic [2:0] MODO_BT_ON  = 3'b010;
   localparam logic [2:0] MODO_BT_RST = 3'b011;

   localparam logic [7:0] ASC_D_UP = 8'h44;  // 'D'
   localparam logic [7:0] ASC_D_LO = 8'h64;  // 'd'
   localparam logic [7:0] ASC_L_UP = 8'h4C;  // 'L'
   localparam logic [7:0] ASC_L_LO = 8'h6C;  // 'l'
   localparam logic [7:0] ASC_B_UP = 8'h42;  // 'B'
   localparam logic [7:0] ASC_B_LO = 8'h62;  // 'b'
   localparam logic [7:0] ASC_R_UP = 8'h52;  // 'R'
   localparam logic [7:0] ASC_R_LO = 8'h72;  // 'r'

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_HIGH
   } rx_state_t;

   typedef struct packed {
      logic       hit;
      logic [2:0] code;
   } decode_t;

   function automatic decode_t decode_letter(input logic [7:0] b);
      decode_t d;
      d.hit  = 1'b1;
      d.code = MODO_OFF;
      case (b)
         ASC_D_UP, ASC_D_LO: d.code = MODO_OFF;
         ASC_L_UP, ASC_L_LO: d.code = MODO_LER;
         ASC_B_UP, ASC_B_LO: d.code = MODO_BT_ON;
         ASC_R_UP, ASC_R_LO: d.code = MODO_BT_RST;
         default:            d.hit  = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//  Oversampling tick generator. Counts 0..DIV-1 while enabled and emits a
//  one-cycle tick on DIV-1. Disabling clears the count, so every enable
//  starts a fresh period from 0.
// Ports:
//  clk     in  system clock
//  rst_n   in  asynchronous active-low reset
//  i_en    in  run the divider (low = hold at 0)
//  o_tick  out one-cycle pulse every DIV enabled cycles
// -----------------------------------------------------------------------------
module uart_baud_tick #(
   parameter int DIV = 325
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   output logic o_tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!i_en || r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/bluetooth_uart_rx.sv
// -----------------------------------------------------------------------------
// bluetooth_uart_rx
//  UART receiver (16x oversampling) for the Bluetooth module's TX line.
//  Recovers bytes and decodes command letters D/L/B/R (any case) into the
//  3-bit mode code for the control unit.
//  Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after
//  the data bits (8E1); undefined gives plain 8N1.
// Ports:
//  clk             in   system clock
//  rst_n           in   asynchronous active-low reset
//  rx_serial       in   raw UART line, idle high, asynchronous
//  habilita        in   receiver enable; low aborts the frame, FSM held IDLE
//  dado[7:0]       out  last correctly framed byte
//  dado_valido     out  1-cycle pulse, dado updated
//  erro_quadro     out  1-cycle pulse, bad stop (or parity), byte discarded
//  comando[2:0]    out  current mode code, held until next recognised letter
//  comando_valido  out  1-cycle pulse with dado_valido for recognised letters
// -----------------------------------------------------------------------------
module bluetooth_uart_rx
   import bluetooth_uart_rx_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_serial,
   input  logic       habilita,
   output logic [7:0] dado,
   output logic       dado_valido,
   output logic       erro_quadro,
   output logic [2:0] comando,
   output logic       comando_valido
);

   localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int TCW = $clog2(OVERSAMPLE);
   localparam logic [TCW-1:0] TC_MID  = TCW'(OVERSAMPLE / 2 - 1);
   localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);

   rx_state_t      r_state, w_state_nxt;
   logic           r_rx_meta, r_rx_sync;
   logic [TCW-1:0] r_tc, w_tc_nxt;
   logic [2:0]     r_bit, w_bit_nxt;
   logic [7:0]     r_shift, w_shift_nxt;
   logic [7:0]     r_dado, w_dado_nxt;
   logic [2:0]     r_cmd, w_cmd_nxt;
   logic           r_dv, w_dv_nxt;
   logic           r_err, w_err_nxt;
   logic           r_cv, w_cv_nxt;
   logic           w_tick;
   logic           w_par_ok;
   decode_t        w_dec;

   // Divider runs only while a frame is in progress; dropping habilita
   // clears it in the same edge as the FSM returns to IDLE.
   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   ((r_state != ST_IDLE) && habilita),
      .o_tick (w_tick)
   );

`ifdef UART_RX_PARITY_EN
   logic r_par, w_par_nxt;
   // Even parity: data bits plus parity bit must XOR to zero.
   assign w_par_ok = ~(^{r_shift, r_par});
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_par <= 1'b0;
      else        r_par <= w_par_nxt;
   end
`else
   assign w_par_ok = 1'b1;
`endif

   assign w_dec = decode_letter(r_shift);

   // Two-flop synchroniser resets to the idle (high) line level so reset
   // release never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= rx_serial;
         r_rx_sync <= r_rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_tc    <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_dado  <= 8'h00;
         r_cmd   <= MODO_OFF;
         r_dv    <= 1'b0;
         r_err   <= 1'b0;
         r_cv    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tc    <= w_tc_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_dado  <= w_dado_nxt;
         r_cmd   <= w_cmd_nxt;
         r_dv    <= w_dv_nxt;
         r_err   <= w_err_nxt;
         r_cv    <= w_cv_nxt;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case, so no path can
      // leave one unassigned and infer a latch.
      w_state_nxt = r_state;
      w_tc_nxt    = r_tc;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_dado_nxt  = r_dado;
      w_cmd_nxt   = r_cmd;
      w_dv_nxt    = 1'b0;
      w_err_nxt   = 1'b0;
      w_cv_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_nxt   = r_par;
`endif
      if (!habilita) begin
         w_state_nxt = ST_IDLE;
         w_tc_nxt    = '0;
         w_bit_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!r_rx_sync) begin
                  w_state_nxt = ST_START;
                  w_tc_nxt    = '0;
                  w_bit_nxt   = '0;
               end
            end
            ST_START: begin
               // Re-check the line half a bit in to reject short glitches.
               if (w_tick) begin
                  if (r_tc == TC_MID) begin
                     w_tc_nxt    = '0;
                     w_state_nxt = r_rx_sync ? ST_IDLE : ST_DATA;
                  end else begin
                     w_tc_nxt = r_tc + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  if (r_tc == TC_LAST) begin
                     w_tc_nxt    = '0;
                     w_shift_nxt = {r_rx_sync, r_shift[7:1]};
                     if (r_bit == 3'd7) begin
                        w_bit_nxt   = '0;
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                     end else begin
                        w_bit_nxt = r_bit + 3'd1;
                     end
                  end else begin
                     w_tc_nxt = r_tc + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (w_tick) begin
                  if (r_tc == TC_LAST) begin
                     w_tc_nxt    = '0;
                     w_par_nxt   = r_rx_sync;
                     w_state_nxt = ST_STOP;
                  end else begin
                     w_tc_nxt = r_tc + 1'b1;
                  end
               end
            end
`endif
            ST_STOP: begin
               if (w_tick) begin
                  if (r_tc == TC_LAST) begin
                     w_tc_nxt = '0;
                     if (r_rx_sync && w_par_ok) begin
                        w_dado_nxt  = r_shift;
                        w_dv_nxt    = 1'b1;
                        w_state_nxt = ST_IDLE;
                        if (w_dec.hit) begin
                           w_cmd_nxt = w_dec.code;
                           w_cv_nxt  = 1'b1;
                        end
                     end else begin
                        // A low stop bit means break or stuck line: wait for
                        // it to return high before hunting for a start bit.
                        w_err_nxt   = 1'b1;
                        w_state_nxt = r_rx_sync ? ST_IDLE : ST_WAIT_HIGH;
                     end
                  end else begin
                     w_tc_nxt = r_tc + 1'b1;
                  end
               end
            end
            ST_WAIT_HIGH: begin
               if (r_rx_sync) w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_tc_nxt    = '0;
               w_bit_nxt   = '0;
            end
         endcase
      end
   end

   assign dado           = r_dado;
   assign dado_valido    = r_dv;
   assign erro_quadro    = r_err;
   assign comando        = r_cmd;
   assign comando_valido = r_cv;

endmodule

// File: tb/tb_bluetooth_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_bluetooth_uart_rx
//  Scoreboard bench for bluetooth_uart_rx. Stimulus pushes the expected
//  pulse record before driving each frame; a negedge monitor pops and
//  compares whenever dado_valido or erro_quadro fires. A scaled clock/baud
//  (DIV = 10, 160 clocks per bit) keeps the run short.
// -----------------------------------------------------------------------------
module tb_bluetooth_uart_rx;

   localparam int CLK_HZ = 1_600_000;
   localparam int BAUD   = 10_000;
   localparam int OVS    = 16;
   localparam int BIT    = CLK_HZ / BAUD;  // 160 clocks per bit

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_serial = 1'b1;
   logic       habilita = 1'b0;
   logic [7:0] dado;
   logic       dado_valido;
   logic       erro_quadro;
   logic [2:0] comando;
   logic       comando_valido;

   bluetooth_uart_rx #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVS)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx_serial      (rx_serial),
      .habilita       (habilita),
      .dado           (dado),
      .dado_valido    (dado_valido),
      .erro_quadro    (erro_quadro),
      .comando        (comando),
      .comando_valido (comando_valido)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_err;
      logic [7:0] dado;
      logic [2:0] cmd;
      logic       cv;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic expect_pulse(input bit is_err, input logic [7:0] d,
                               input logic [2:0] c, input logic cv);
      exp_t e;
      e.is_err = is_err;
      e.dado   = d;
      e.cmd    = c;
      e.cv     = cv;
      exp_q.push_back(e);
   endtask

   // Drives one frame LSB first. hab_drop_bit / rst_bit (-1 = unused) drop
   // habilita or pulse reset at the start of that data bit.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                            input int hab_drop_bit, input int rst_bit);
      logic [7:0] v;
      v = b;
      rx_serial = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         if (i == hab_drop_bit) habilita = 1'b0;
         if (i == rst_bit) begin
            rst_n = 1'b0;
            repeat (3) @(negedge clk);
            rx_serial = 1'b1;
            rst_n = 1'b1;
            return;
         end
         rx_serial = v[i];
         repeat (BIT) @(negedge clk);
      end
      rx_serial = stop_bit;
      repeat (BIT) @(negedge clk);
      rx_serial = 1'b1;
   endtask

   task automatic idle_bits(input int n);
      repeat (n * BIT) @(negedge clk);
   endtask

   // Monitor: every output pulse must match the oldest outstanding record.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (dado_valido || erro_quadro) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_pulse: dv=%0b err=%0b dado=%02h, expected no pulse (t=%0t)",
                     dado_valido, erro_quadro, dado, $time);
         end else begin
            e = exp_q.pop_front();
            check("pulse_is_err",   {31'd0, erro_quadro},    {31'd0, e.is_err});
            check("pulse_is_valid", {31'd0, dado_valido},    {31'd0, !e.is_err});
            check("dado",           {24'd0, dado},           {24'd0, e.dado});
            check("comando",        {29'd0, comando},        {29'd0, e.cmd});
            check("comando_valido", {31'd0, comando_valido}, {31'd0, e.cv});
         end
      end
      if (comando_valido && !dado_valido) begin
         n_checks++;
         $display("FAIL cv_without_dv: comando_valido=1 dado_valido=0, expected both (t=%0t)", $time);
      end
   end

   initial begin
      // Reset values.
      repeat (5) @(negedge clk);
      check("rst_dado",    {24'd0, dado},           32'h00);
      check("rst_comando", {29'd0, comando},        32'h0);
      check("rst_dv",      {31'd0, dado_valido},    32'h0);
      check("rst_err",     {31'd0, erro_quadro},    32'h0);
      check("rst_cv",      {31'd0, comando_valido}, 32'h0);
      rst_n = 1'b1;
      habilita = 1'b1;
      idle_bits(2);

      // 'L' -> read sensor.
      expect_pulse(1'b0, 8'h4C, 3'b001, 1'b1);
      send_byte(8'h4C, 1'b1, -1, -1);
      idle_bits(2);

      // 'B' then 'r' with no idle gap.
      expect_pulse(1'b0, 8'h42, 3'b010, 1'b1);
      expect_pulse(1'b0, 8'h72, 3'b011, 1'b1);
      send_byte(8'h42, 1'b1, -1, -1);
      send_byte(8'h72, 1'b1, -1, -1);
      idle_bits(2);

      // 'A' is not a command: byte delivered, mode unchanged.
      expect_pulse(1'b0, 8'h41, 3'b011, 1'b0);
      send_byte(8'h41, 1'b1, -1, -1);
      idle_bits(2);

      // 0x44 with stop bit 0, line low three bit times in total.
      expect_pulse(1'b1, 8'h41, 3'b011, 1'b0);
      send_byte(8'h44, 1'b0, -1, -1);
      rx_serial = 1'b0;
      idle_bits(2);
      rx_serial = 1'b1;
      idle_bits(2);

      // Short low glitch on idle line (quarter bit): nothing expected.
      rx_serial = 1'b0;
      repeat (BIT / 4) @(negedge clk);
      rx_serial = 1'b1;
      idle_bits(2);

      // Drop habilita at bit 4 of 'L': no pulses, outputs hold.
      send_byte(8'h4C, 1'b1, 4, -1);
      idle_bits(1);
      check("hold_dado",    {24'd0, dado},    32'h41);
      check("hold_comando", {29'd0, comando}, 32'h3);
      habilita = 1'b1;
      idle_bits(1);

      // 'D' -> off.
      expect_pulse(1'b0, 8'h44, 3'b000, 1'b1);
      send_byte(8'h44, 1'b1, -1, -1);
      idle_bits(2);

      // 'R' -> BT reset, then reset asserted at bit 4 of 'L'.
      expect_pulse(1'b0, 8'h52, 3'b011, 1'b1);
      send_byte(8'h52, 1'b1, -1, -1);
      idle_bits(2);
      send_byte(8'h4C, 1'b1, -1, 4);
      repeat (2) @(negedge clk);
      check("midrst_dado",    {24'd0, dado},    32'h00);
      check("midrst_comando", {29'd0, comando}, 32'h0);
      idle_bits(2);

      // Lower-case letters after reset.
      expect_pulse(1'b0, 8'h62, 3'b010, 1'b1);
      send_byte(8'h62, 1'b1, -1, -1);
      idle_bits(1);
      expect_pulse(1'b0, 8'h64, 3'b000, 1'b1);
      send_byte(8'h64, 1'b1, -1, -1);

      // Bounded wait for the scoreboard to drain.
      for (int i = 0; i < 4 * BIT && exp_q.size() != 0; i++) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      idle_bits(1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
